// File: rtl/list_prefetcher_if.sv
// rtl/list_prefetcher_if.sv - line-in / word-out handshake bundle for list_prefetcher
interface list_prefetcher_if #(
  parameter int DW  = 32,
  parameter int DBW = 256
);
  logic [DBW-1:0] S0_AXIS_TDATA;
  logic           S0_AXIS_TVALID;
  logic           S0_AXIS_TLAST;
  logic           S0_AXIS_TREADY;
  logic [DW-1:0]  OUT;
  logic           O_VALID;
  logic           O_LAST;
  logic           I_READY;

  modport master (
    output S0_AXIS_TDATA, S0_AXIS_TVALID, S0_AXIS_TLAST, I_READY,
    input  S0_AXIS_TREADY, OUT, O_VALID, O_LAST
  );

  modport slave (
    input  S0_AXIS_TDATA, S0_AXIS_TVALID, S0_AXIS_TLAST, I_READY,
    output S0_AXIS_TREADY, OUT, O_VALID, O_LAST
  );
endinterface

// File: rtl/list_prefetcher.sv
// rtl/list_prefetcher.sv - unpacks DBW-bit stream lines into DW-bit words via a DEPTH-line ring
// Optional LEVEL (unread word count) output is enabled by LIST_PREFETCHER_LEVEL_EN.
module list_prefetcher #(
  parameter int DW         = 32,
  parameter int DBW        = 256,
  parameter int DEPTH      = 2,
  parameter int WORD_ORDER = 0
) (
  input  logic ACLK,
  input  logic ARESET,
  list_prefetcher_if.slave bus
`ifdef LIST_PREFETCHER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH*(DBW/DW)):0] LEVEL
`endif
);

  localparam int FS = DBW / DW;
  localparam int IW = $clog2(FS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DBW-1:0] line_mem [DEPTH];
  logic [DEPTH-1:0] last_flag;
  logic [PW-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [IW-1:0]  word_idx, word_idx_nxt, sel;
  logic [CW-1:0]  line_cnt, line_cnt_nxt;
  logic           ready_q;
  logic           push, pop, head_done;
  logic [DW-1:0]  head_words [FS];

  // TREADY is a flop so a release on a full cycle cannot pass a new line straight through.
  assign bus.S0_AXIS_TREADY = ready_q;
  assign bus.O_VALID        = (line_cnt != '0);

  assign push      = bus.S0_AXIS_TVALID & ready_q;
  assign pop       = bus.O_VALID & bus.I_READY;
  assign head_done = pop & (word_idx == IW'(FS - 1));

  always_comb begin
    for (int i = 0; i < FS; i++) begin
      head_words[i] = line_mem[rd_ptr][i*DW +: DW];
    end
    sel = (WORD_ORDER != 0) ? (IW'(FS - 1) - word_idx) : word_idx;
  end

  assign bus.OUT    = bus.O_VALID ? head_words[sel] : '0;
  assign bus.O_LAST = bus.O_VALID & last_flag[rd_ptr] & (word_idx == IW'(FS - 1));

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    word_idx_nxt = word_idx;
    line_cnt_nxt = line_cnt;
    if (push)      wr_ptr_nxt   = wr_ptr + 1'b1;
    if (pop)       word_idx_nxt = word_idx + 1'b1;
    if (head_done) rd_ptr_nxt   = rd_ptr + 1'b1;
    case ({push, head_done})
      2'b10:   line_cnt_nxt = line_cnt + 1'b1;
      2'b01:   line_cnt_nxt = line_cnt - 1'b1;
      default: line_cnt_nxt = line_cnt;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      word_idx  <= '0;
      line_cnt  <= '0;
      last_flag <= '0;
      ready_q   <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      word_idx <= word_idx_nxt;
      line_cnt <= line_cnt_nxt;
      ready_q  <= (line_cnt_nxt < CW'(DEPTH));
      if (push) last_flag[wr_ptr] <= bus.S0_AXIS_TLAST;
    end
  end

  // Line payload is left uncleared on reset; line_cnt alone decides what is valid.
  always_ff @(posedge ACLK) begin
    if (push) line_mem[wr_ptr] <= bus.S0_AXIS_TDATA;
  end

`ifdef LIST_PREFETCHER_LEVEL_EN
  localparam int LW = $clog2(DEPTH*FS) + 1;
  assign LEVEL = (LW'(line_cnt) << IW) - LW'(word_idx);
`endif

endmodule
